dmem_lsu: RTL
=============

Name: dmem_lsu

Overview:
Load/store unit directly upstream of DMEM. Takes one memory request per transaction from the MEM stage and converts LB/LH/LW/LBU/LHU/SB/SH/SW into word-aligned DMEM accesses. Sub-word stores use read-modify-write, because DMEM only writes whole little-endian words. Loads are sign- or zero-extended; misaligned, out-of-range and illegal requests are flagged. The pipeline stalls on busy.

Parameters:
DMEM_ADDR_WIDTH, `DMEM_ADDR_WIDTH, byte address width toward DMEM
REG_WIDTH, `REG_WIDTH, data width; must be 32
DMEM_DEPTH, `DMEM_DEPTH, DMEM size in bytes; a multiple of 4

Ports:
clk  in  1  clock, single domain
reset_n  in  1  asynchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  high only in IDLE; request accepted on a posedge where valid&&ready
req_we  in  1  1 = store, 0 = load
req_funct3  in  3  RISC-V width code: 000 B, 001 H, 010 W, 100 BU, 101 HU
req_addr  in  DMEM_ADDR_WIDTH  byte address
req_wdata  in  REG_WIDTH  store data; low byte/half used for SB/SH
resp_valid  out  1  one-cycle completion pulse
resp_rdata  out  REG_WIDTH  extended load data; 0 for stores and errors
resp_err  out  1  valid with resp_valid; misaligned, out-of-range or illegal funct3
busy  out  1  high in any state except IDLE
dmem_wr_en  out  1  to DMEM wr_en
dmem_addr  out  DMEM_ADDR_WIDTH  to DMEM addr; always word-aligned
dmem_wr_data  out  REG_WIDTH  to DMEM wr_data
dmem_rd_data  in  REG_WIDTH  from DMEM data_out; updated on negedge

Behaviour:
- Reset (async, any state): state=IDLE. resp_valid=0, resp_rdata=0, resp_err=0, dmem_wr_en=0, dmem_addr=0, dmem_wr_data=0, all latched request fields=0.
- On accept, latch req_we, req_funct3, req_addr, req_wdata. The req_* inputs are ignored while busy.
- dmem_* outputs are decoded only from the state register and latched fields; no combinational path from req_*. They are 0 outside RD/WR.
- Error checks at accept:
  - Illegal funct3: load 011/110/111; store anything other than 000/001/010.
  - Misaligned: H/HU with addr[0]≠0; W with addr[1:0]≠0.
  - Out of range: (addr & ~3)+3 > DMEM_DEPTH-1.
  - Any error → RESP with err=1, rdata=0; DMEM is never written.
- States: IDLE, RD, WR, RESP.
  - IDLE → RD on load, or on SB/SH.
  - IDLE → WR on SW.
  - IDLE → RESP on error.
  - RD: dmem_addr = addr&~3, wr_en=0. DMEM presents data at negedge. At the next posedge, latch dmem_rd_data. Load → RESP with extracted/extended value. SB/SH → WR with the merged word.
  - WR: dmem_wr_en=1, dmem_addr = addr&~3, dmem_wr_data = full word (SW) or merged word (SB/SH). The write commits at the posedge ending WR → RESP.
  - RESP: resp_valid=1 for exactly one cycle → IDLE. resp_rdata/resp_err hold until the next RESP or reset.
- Latency from accept edge to resp_valid: load 2 cycles, SW 2, SB/SH 3, error 1. Throughput: a new accept is possible the cycle after RESP.
- Extract (lane = addr[1:0]):
  - B: byte lane sign-extended; BU: zero-extended.
  - H: half at addr[1] sign-extended; HU: zero-extended.
- Merge: replace only the addressed byte/half of the read word with wdata[7:0] or wdata[15:0]; all other bytes unchanged.
- Reset during RD or WR: the transaction is aborted, no resp_valid, and no write is issued after reset release.

Decomposition:
- risc_v_defines.vh gains:
  - LSU funct3 codes: `LSU_B, `LSU_H, `LSU_W, `LSU_BU, `LSU_HU.
  - State encodings: `LSU_IDLE/RD/WR/RESP, 2-bit.
- One purely combinational sub-module, lsu_align: inputs funct3, addr[1:0], rdata, wdata; outputs load_ext and store_merge.
- dmem_lsu keeps the FSM, the request latches and the error checks.

Test Plan (bench instantiates dmem_lsu+DMEM with DMEM_DEPTH=1024; reset contents word@i = 1024-i):
1. After reset, LW addr 8 → resp_valid 2 cycles after accept, rdata=0x000003F8, err=0.
2. SB addr 5 data 0x123456AB → exactly one dmem_wr_en cycle, data 0x0000ABFC at addr 4. Then LB addr 5 → 0xFFFFFFAB; LBU addr 5 → 0x000000AB.
3. SH addr 2 data 0x8001 → word@0 = 0x80010400. LH addr 2 → 0xFFFF8001; LHU addr 2 → 0x00008001; LW addr 0 → 0x80010400.
4. LW addr 6, SH addr 3, LW addr 1022, funct3 011 → resp_err=1, rdata=0, dmem_wr_en never asserted, 1-cycle latency.
5. Hold req_valid high for 3 back-to-back SW (addr 0/4/8, data 1/2/3) → req_ready low during busy, exactly 3 accepts. Readback gives 1, 2, 3.
6. Assert reset_n=0 during the RD state of SB addr 9 → no write and no resp_valid; all outputs read 0 immediately. After release, LW addr 8 = 0x000003F8.

Source files
------------

// File: rtl/dmem_lsu_pkg.sv
// Shared types, width codes and request-check helpers for the DMEM load/store unit.
package dmem_lsu_pkg;

  localparam int DMEM_ADDR_WIDTH_DEF = 12;
  localparam int REG_WIDTH_DEF       = 32;
  localparam int DMEM_DEPTH_DEF      = 1024;

  localparam logic [2:0] LSU_B  = 3'b000;
  localparam logic [2:0] LSU_H  = 3'b001;
  localparam logic [2:0] LSU_W  = 3'b010;
  localparam logic [2:0] LSU_BU = 3'b100;
  localparam logic [2:0] LSU_HU = 3'b101;

  typedef enum logic [1:0] {
    LSU_IDLE = 2'b00,
    LSU_RD   = 2'b01,
    LSU_WR   = 2'b10,
    LSU_RESP = 2'b11
  } lsu_state_e;

  function automatic logic funct3_illegal(input logic we, input logic [2:0] f3);
    logic bad;
    if (we) begin
      bad = !((f3 == LSU_B) || (f3 == LSU_H) || (f3 == LSU_W));
    end else begin
      bad = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
    end
    return bad;
  endfunction

  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] a);
    logic bad;
    case (f3)
      LSU_H, LSU_HU: bad = a[0];
      LSU_W:         bad = (a != 2'b00);
      default:       bad = 1'b0;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/dmem_lsu_if.sv
// Request/response handshake toward the MEM stage plus the word port toward DMEM.
interface dmem_lsu_if #(
  parameter int AW = 12,
  parameter int DW = 32
) ();
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [2:0]    req_funct3;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          resp_valid;
  logic [DW-1:0] resp_rdata;
  logic          resp_err;
  logic          busy;
  logic          dmem_wr_en;
  logic [AW-1:0] dmem_addr;
  logic [DW-1:0] dmem_wr_data;
  logic [DW-1:0] dmem_rd_data;

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err, busy
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, dmem_rd_data,
    output req_ready, resp_valid, resp_rdata, resp_err, busy,
           dmem_wr_en, dmem_addr, dmem_wr_data
  );

  modport mem (
    input  dmem_wr_en, dmem_addr, dmem_wr_data,
    output dmem_rd_data
  );
endinterface

// File: rtl/dmem_lsu_align.sv
// Byte/half lane extraction for loads and read-modify-write merge for sub-word stores.
module lsu_align
  import dmem_lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr,
  input  logic [31:0] rdata,
  input  logic [31:0] wdata,
  output logic [31:0] load_ext,
  output logic [31:0] store_merge
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;
  logic [4:0]  bsh_s;
  logic [4:0]  hsh_s;

  // Load path: select the addressed lane and extend it.
  always_comb begin
    bsh_s  = {addr, 3'b000};
    hsh_s  = {addr[1], 4'b0000};
    byte_s = 8'(rdata >> bsh_s);
    half_s = 16'(rdata >> hsh_s);
    case (funct3)
      LSU_B:   load_ext = {{24{byte_s[7]}}, byte_s};
      LSU_BU:  load_ext = {24'h000000, byte_s};
      LSU_H:   load_ext = {{16{half_s[15]}}, half_s};
      LSU_HU:  load_ext = {16'h0000, half_s};
      default: load_ext = rdata;
    endcase
  end

  // Store path: overwrite only the addressed lane, keep the rest of the read word.
  always_comb begin
    case (funct3)
      LSU_B:   store_merge = (rdata & ~(32'h0000_00FF << bsh_s)) |
                             ({24'h000000, wdata[7:0]} << bsh_s);
      LSU_H:   store_merge = (rdata & ~(32'h0000_FFFF << hsh_s)) |
                             ({16'h0000, wdata[15:0]} << hsh_s);
      default: store_merge = wdata;
    endcase
  end

endmodule

// File: rtl/dmem_lsu.sv
// Load/store unit in front of word-wide DMEM: request latch, error checks and access FSM.
module dmem_lsu
  import dmem_lsu_pkg::*;
#(
  parameter int DMEM_ADDR_WIDTH = DMEM_ADDR_WIDTH_DEF,
  parameter int REG_WIDTH       = REG_WIDTH_DEF,
  parameter int DMEM_DEPTH      = DMEM_DEPTH_DEF
) (
  input logic      clk,
  input logic      reset_n,
  dmem_lsu_if.slave lsu
);

  localparam int AW = DMEM_ADDR_WIDTH;

  lsu_state_e           state_r;
  lsu_state_e           state_s;
  logic                 we_r;
  logic [2:0]           funct3_r;
  logic [AW-1:0]        addr_r;
  logic [REG_WIDTH-1:0] wdata_r;
  logic [REG_WIDTH-1:0] resp_rdata_r;
  logic                 resp_err_r;
  logic                 accept_s;
  logic                 err_s;
  logic [AW-1:0]        req_word_s;
  logic [31:0]          load_ext_s;
  logic [31:0]          store_merge_s;

  lsu_align u_align (
    .funct3      (funct3_r),
    .addr        (addr_r[1:0]),
    .rdata       (lsu.dmem_rd_data),
    .wdata       (wdata_r),
    .load_ext    (load_ext_s),
    .store_merge (store_merge_s)
  );

  // Request legality: funct3, alignment and last byte of the word inside DMEM.
  always_comb begin
    req_word_s = {lsu.req_addr[AW-1:2], 2'b00};
    accept_s   = lsu.req_valid && (state_r == LSU_IDLE);
    err_s      = funct3_illegal(lsu.req_we, lsu.req_funct3) ||
                 misaligned(lsu.req_funct3, lsu.req_addr[1:0]) ||
                 ((32'(req_word_s) + 32'd3) > 32'(DMEM_DEPTH - 1));
  end

  // Next-state decode.
  always_comb begin
    state_s = state_r;
    case (state_r)
      LSU_IDLE: begin
        if (accept_s) begin
          if (err_s) begin
            state_s = LSU_RESP;
          end else if (lsu.req_we && (lsu.req_funct3 == LSU_W)) begin
            state_s = LSU_WR;
          end else begin
            state_s = LSU_RD;
          end
        end else begin
          state_s = LSU_IDLE;
        end
      end
      LSU_RD:   state_s = we_r ? LSU_WR : LSU_RESP;
      LSU_WR:   state_s = LSU_RESP;
      LSU_RESP: state_s = LSU_IDLE;
      default:  state_s = LSU_IDLE;
    endcase
  end

  // State, request latches and response data registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r      <= LSU_IDLE;
      we_r         <= 1'b0;
      funct3_r     <= 3'b000;
      addr_r       <= '0;
      wdata_r      <= '0;
      resp_rdata_r <= '0;
      resp_err_r   <= 1'b0;
    end else begin
      state_r <= state_s;
      case (state_r)
        LSU_IDLE: begin
          if (accept_s) begin
            we_r     <= lsu.req_we;
            funct3_r <= lsu.req_funct3;
            addr_r   <= lsu.req_addr;
            wdata_r  <= lsu.req_wdata;
            if (err_s) begin
              resp_rdata_r <= '0;
              resp_err_r   <= 1'b1;
            end
          end
        end
        LSU_RD: begin
          if (we_r) begin
            wdata_r <= store_merge_s;
          end else begin
            resp_rdata_r <= load_ext_s;
            resp_err_r   <= 1'b0;
          end
        end
        LSU_WR: begin
          resp_rdata_r <= '0;
          resp_err_r   <= 1'b0;
        end
        default: begin
          resp_rdata_r <= resp_rdata_r;
        end
      endcase
    end
  end

  // Outputs decoded from registered state only; DMEM port idles at zero.
  always_comb begin
    lsu.req_ready    = (state_r == LSU_IDLE);
    lsu.busy         = (state_r != LSU_IDLE);
    lsu.resp_valid   = (state_r == LSU_RESP);
    lsu.resp_rdata   = resp_rdata_r;
    lsu.resp_err     = resp_err_r;
    lsu.dmem_wr_en   = 1'b0;
    lsu.dmem_addr    = '0;
    lsu.dmem_wr_data = '0;
    case (state_r)
      LSU_RD: begin
        lsu.dmem_addr = {addr_r[AW-1:2], 2'b00};
      end
      LSU_WR: begin
        lsu.dmem_wr_en   = 1'b1;
        lsu.dmem_addr    = {addr_r[AW-1:2], 2'b00};
        lsu.dmem_wr_data = wdata_r;
      end
      default: begin
        lsu.dmem_wr_en = 1'b0;
      end
    endcase
  end

endmodule
